// File: rtl/led_anim_pkg.sv
// Shared types for the LED animation front panel: mode encodings, mode bus type
// and the per-button press state machine encoding.
package led_anim_pkg;

    localparam int unsigned MODE_W = 2;

    typedef logic [MODE_W-1:0] mode_t;

    typedef enum logic [MODE_W-1:0] {
        MODE_SHIFT     = 2'd0,
        MODE_BAR       = 2'd1,
        MODE_PWM_CHAIN = 2'd2,
        MODE_RSVD      = 2'd3
    } mode_enc_e;

    typedef enum logic [1:0] {
        PRESS_IDLE   = 2'd0,
        PRESS_HELD   = 2'd1,
        PRESS_REPEAT = 2'd2
    } press_state_t;

endpackage

// File: rtl/btn_conditioner.sv
// One pushbutton: 2-flop synchronizer, run-length debounce and a press FSM that
// emits a step on the debounced rise, after the hold time, and then periodically.
module btn_conditioner
    import led_anim_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = 20,
    parameter int unsigned HOLD_CYCLES   = 2000,
    parameter int unsigned REPEAT_CYCLES = 500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic step
);

    localparam int unsigned DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned REP_W  = $clog2(REPEAT_CYCLES + 1);
    localparam int unsigned TMR_W  = (HOLD_W > REP_W) ? HOLD_W : REP_W;

    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             step_q, step_d;
    logic             rise, fall;
    press_state_t     state_q, state_d;

    // State register: synchronizer, debounce, press FSM and its timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b00;
            level_q   <= 1'b0;
            deb_cnt_q <= '0;
            tmr_q     <= '0;
            step_q    <= 1'b0;
            state_q   <= PRESS_IDLE;
        end else begin
            sync_q    <= {sync_q[0], raw};
            level_q   <= level_d;
            deb_cnt_q <= deb_cnt_d;
            tmr_q     <= tmr_d;
            step_q    <= step_d;
            state_q   <= state_d;
        end
    end

    // Next-state logic; the step is registered on the same edge the level rises
    always_comb begin
        level_d   = level_q;
        deb_cnt_d = '0;
        tmr_d     = tmr_q;
        step_d    = 1'b0;
        state_d   = state_q;

        if (sync_q[1] != level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                level_d = ~level_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end

        rise = level_d & ~level_q;
        fall = ~level_d & level_q;

        case (state_q)
            PRESS_IDLE: begin
                if (rise) begin
                    state_d = PRESS_HELD;
                    step_d  = 1'b1;
                    tmr_d   = '0;
                end
            end
            PRESS_HELD: begin
                if (fall) begin
                    state_d = PRESS_IDLE;
                    tmr_d   = '0;
                end else if (tmr_q == HOLD_LAST) begin
                    state_d = PRESS_REPEAT;
                    step_d  = 1'b1;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            PRESS_REPEAT: begin
                if (fall) begin
                    state_d = PRESS_IDLE;
                    tmr_d   = '0;
                end else if (tmr_q == REP_LAST) begin
                    step_d = 1'b1;
                    tmr_d  = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = PRESS_IDLE;
                tmr_d   = '0;
            end
        endcase
    end

    assign level = level_q;
    assign step  = step_q;

endmodule

// File: rtl/led_mode_selector.sv
// Front-panel mode selector: two conditioned buttons step a wrapping mode
// register, gated by lock, with a one-cycle strobe on every real change.
module led_mode_selector
    import led_anim_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = 20,
    parameter int unsigned HOLD_CYCLES   = 2000,
    parameter int unsigned REPEAT_CYCLES = 500,
    parameter int unsigned NUM_MODES     = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_next,
    input  logic        btn_prev,
    input  logic        lock,
    output logic [1:0]  mode,
    output logic        mode_chg,
    output logic [1:0]  btn_level
);

    localparam mode_t MODE_LAST = MODE_W'(NUM_MODES - 1);

    logic  level_next, level_prev;
    logic  step_next, step_prev;
    mode_t mode_d;
    logic  chg_d;

    btn_conditioner #(
        .DEB_CYCLES    (DEB_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_next (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_next),
        .level (level_next),
        .step  (step_next)
    );

    btn_conditioner #(
        .DEB_CYCLES    (DEB_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_prev (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_prev),
        .level (level_prev),
        .step  (step_prev)
    );

    // Coincident next/prev steps cancel; locked steps are dropped outright
    always_comb begin
        mode_d = mode;
        chg_d  = 1'b0;
        if (!lock && (step_next ^ step_prev)) begin
            if (step_next) begin
                mode_d = (mode == MODE_LAST) ? mode_t'(MODE_SHIFT) : mode + mode_t'(1);
            end else begin
                mode_d = (mode == mode_t'(MODE_SHIFT)) ? MODE_LAST : mode - mode_t'(1);
            end
            chg_d = (mode_d != mode);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode     <= mode_t'(MODE_SHIFT);
            mode_chg <= 1'b0;
        end else begin
            mode     <= mode_d;
            mode_chg <= chg_d;
        end
    end

    assign btn_level = {level_prev, level_next};

endmodule

// File: tb/tb_led_mode_selector.sv
// Bench for led_mode_selector: directed scenarios plus random button activity,
// every cycle compared against a behavioural model built from press timing.
module tb_led_mode_selector;

    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;
    localparam int NM   = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_next;
    logic       btn_prev;
    logic       lock;
    logic [1:0] mode;
    logic       mode_chg;
    logic [1:0] btn_level;

    int total = 0;
    int bad   = 0;
    int chg_seen = 0;

    // Model state: index 0 = next, 1 = prev
    bit m_s1[2];
    bit m_s2[2];
    bit m_lvl[2];
    int m_run[2];
    int m_since[2];
    bit m_step[2];
    int m_mode;
    bit m_chg;

    led_mode_selector #(
        .DEB_CYCLES    (DEB),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP),
        .NUM_MODES     (NM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_next  (btn_next),
        .btn_prev  (btn_prev),
        .lock      (lock),
        .mode      (mode),
        .mode_chg  (mode_chg),
        .btn_level (btn_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0;
            m_run[b] = 0; m_since[b] = -1; m_step[b] = 0;
        end
        m_mode = 0;
        m_chg  = 0;
    endtask

    // One clock edge of the reference behaviour, using inputs stable at that edge
    task automatic model_edge();
        int  delta;
        bit  raw;
        bit  toggled;
        bit  st;
        if (!rst_n) begin
            model_reset();
            return;
        end
        delta = int'(m_step[0]) - int'(m_step[1]);
        if (lock || delta == 0) begin
            m_chg = 0;
        end else begin
            m_mode = (m_mode + delta + NM) % NM;
            m_chg  = 1;
        end
        for (int b = 0; b < 2; b++) begin
            raw = (b == 0) ? btn_next : btn_prev;
            toggled = 0;
            st = 0;
            if (m_s2[b] != m_lvl[b]) begin
                m_run[b]++;
                if (m_run[b] == DEB) begin
                    m_lvl[b] = ~m_lvl[b];
                    m_run[b] = 0;
                    toggled = 1;
                end
            end else begin
                m_run[b] = 0;
            end
            if (toggled && m_lvl[b]) begin
                m_since[b] = 0;
                st = 1;
            end else if (toggled) begin
                m_since[b] = -1;
            end else if (m_since[b] >= 0) begin
                m_since[b]++;
                st = (m_since[b] == HOLD) ||
                     (m_since[b] > HOLD && (m_since[b] - HOLD) % REP == 0);
            end
            m_step[b] = st;
            m_s2[b] = m_s1[b];
            m_s1[b] = raw;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (mode_chg === 1'b1) chg_seen++;
        check("mode", 32'(mode), 32'(m_mode));
        check("mode_chg", 32'(mode_chg), 32'(m_chg));
        check("btn_level", 32'(btn_level), 32'({m_lvl[1], m_lvl[0]}));
    endtask

    task automatic press(input logic n, input logic p, input int hold);
        btn_next = n;
        btn_prev = p;
        repeat (hold) tick();
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (12) tick();
    endtask

    initial begin
        int c0;
        rst_n    = 1'b0;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        lock     = 1'b0;
        model_reset();
        repeat (2) tick();
        check("reset_mode", 32'(mode), 32'd0);
        check("reset_chg", 32'(mode_chg), 32'd0);
        check("reset_level", 32'(btn_level), 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Single next press: level at edge 6, mode at edge 7 only
        btn_next = 1'b1;
        c0 = chg_seen;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 5) check("press_level_e5", 32'(btn_level), 32'd0);
            if (i == 6) begin
                check("press_level_e6", 32'(btn_level), 32'd1);
                check("press_mode_e6", 32'(mode), 32'd0);
            end
            if (i == 7) begin
                check("press_mode_e7", 32'(mode), 32'd1);
                check("press_chg_e7", 32'(mode_chg), 32'd1);
            end
            if (i == 8) check("press_chg_e8", 32'(mode_chg), 32'd0);
        end
        btn_next = 1'b0;
        repeat (12) tick();
        check("press_strobes", 32'(chg_seen - c0), 32'd1);

        // Bounce shorter than the debounce window
        c0 = chg_seen;
        btn_next = 1'b1; repeat (3) tick();
        btn_next = 1'b0; repeat (1) tick();
        btn_next = 1'b1; repeat (3) tick();
        btn_next = 1'b0; repeat (10) tick();
        check("bounce_mode", 32'(mode), 32'd1);
        check("bounce_strobes", 32'(chg_seen - c0), 32'd0);

        // Wrap forward and backward
        press(1'b1, 1'b0, 10);
        check("wrap_2", 32'(mode), 32'd2);
        press(1'b1, 1'b0, 10);
        check("wrap_0", 32'(mode), 32'd0);
        c0 = chg_seen;
        press(1'b0, 1'b1, 10);
        check("wrap_prev", 32'(mode), 32'd2);
        check("wrap_prev_strobes", 32'(chg_seen - c0), 32'd1);
        press(1'b1, 1'b0, 10);
        check("back_to_0", 32'(mode), 32'd0);

        // Held button auto-repeat from mode 0
        btn_next = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (i == 6)  check("hold_level_e6", 32'(btn_level), 32'd1);
            if (i == 7)  check("hold_mode_e7", 32'(mode), 32'd1);
            if (i == 26) check("hold_mode_e26", 32'(mode), 32'd1);
            if (i == 27) check("hold_mode_e27", 32'(mode), 32'd2);
            if (i == 34) begin
                check("hold_mode_e34", 32'(mode), 32'd2);
                btn_next = 1'b0;
            end
            if (i == 35) check("hold_mode_e35", 32'(mode), 32'd0);
        end
        check("hold_after_release", 32'(mode), 32'd0);

        // Simultaneous presses cancel
        c0 = chg_seen;
        press(1'b1, 1'b1, 10);
        check("both_mode", 32'(mode), 32'd0);
        check("both_strobes", 32'(chg_seen - c0), 32'd0);

        // Locked press is dropped, not replayed
        lock = 1'b1;
        press(1'b1, 1'b0, 10);
        lock = 1'b0;
        repeat (5) tick();
        check("lock_mode", 32'(mode), 32'd0);

        // Lock released mid-hold: later repeats are honoured
        lock = 1'b1;
        btn_next = 1'b1;
        for (int i = 1; i <= 34; i++) begin
            tick();
            if (i == 15) lock = 1'b0;
        end
        btn_next = 1'b0;
        repeat (15) tick();
        check("lock_hold_mode", 32'(mode), 32'd2);

        // Reset during HELD at mode 2, button kept held through reset
        press(1'b1, 1'b0, 10);
        press(1'b1, 1'b0, 10);
        check("pre_rst_mode1", 32'(mode), 32'd1);
        btn_next = 1'b1;
        repeat (12) tick();
        check("pre_rst_mode2", 32'(mode), 32'd2);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_mid_mode", 32'(mode), 32'd0);
        check("rst_mid_chg", 32'(mode_chg), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 6) check("rst_rel_mode_e6", 32'(mode), 32'd0);
            if (i == 7) begin
                check("rst_rel_mode_e7", 32'(mode), 32'd1);
                check("rst_rel_chg_e7", 32'(mode_chg), 32'd1);
            end
        end
        btn_next = 1'b0;
        repeat (12) tick();

        // Random button, bounce and lock activity
        for (int n = 0; n < 40; n++) begin
            btn_next = 1'($urandom_range(0, 1));
            btn_prev = 1'($urandom_range(0, 1));
            lock     = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(1, 45)) tick();
        end
        btn_next = 1'b0;
        btn_prev = 1'b0;
        lock     = 1'b0;
        repeat (20) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
